// File: rtl/deskew_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deskew_ctrl_pkg
// Description : Shared definitions for the deskew control block: register
//               indices, CTRL/STATUS bit positions, the ID constant and the
//               job-sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package deskew_ctrl_pkg;

   // Register indices
   localparam int unsigned c_reg_ctrl     = 0;
   localparam int unsigned c_reg_status   = 1;
   localparam int unsigned c_reg_img_dim  = 2;
   localparam int unsigned c_reg_in_addr  = 3;
   localparam int unsigned c_reg_out_addr = 4;
   localparam int unsigned c_reg_id       = 5;

   // CTRL bit positions
   localparam int unsigned c_ctrl_start_bit  = 0;
   localparam int unsigned c_ctrl_irq_en_bit = 1;

   // STATUS bit positions
   localparam int unsigned c_stat_busy_bit    = 0;
   localparam int unsigned c_stat_done_bit    = 1;
   localparam int unsigned c_stat_cfg_err_bit = 2;

   // Read-only identification value
   localparam logic [31:0] c_id_value = 32'hDE5C_0001;

   // Job-sequencer state encoding
   localparam logic [2:0] c_st_idle       = 3'd0;
   localparam logic [2:0] c_st_check      = 3'd1;
   localparam logic [2:0] c_st_wait_check = 3'd2;
   localparam logic [2:0] c_st_launch     = 3'd3;
   localparam logic [2:0] c_st_wait_core  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE       = c_st_idle,
      ST_CHECK      = c_st_check,
      ST_WAIT_CHECK = c_st_wait_check,
      ST_LAUNCH     = c_st_launch,
      ST_WAIT_CORE  = c_st_wait_core
   } state_e;

endpackage : deskew_ctrl_pkg
`default_nettype wire

// File: rtl/deskew_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : deskew_ctrl
// Description : Host register file and job sequencer for the deskew IP.
//               Holds image dimension and start-address registers (driven
//               straight to cfg_check and the core), runs each job as
//               check -> verdict -> launch (or error), and reports status
//               and a level interrupt back to the host.
// Ports       : clk, rst_n (async, active-low)
//               reg_wr_en/reg_rd_en/reg_addr/reg_wdata : host register bus
//               reg_rdata/reg_rvalid                   : registered read return
//               img_dim, in_img_start_addr, out_img_start_addr : job config
//               cfg_check_en / cfg_ok / cfg_check_done : config check handshake
//               core_start / core_done                 : core handshake
//               irq                                    : IRQ_EN & DONE
// Revision    : 1.0 - initial release
// ============================================================================
module deskew_ctrl
   import deskew_ctrl_pkg::*;
#(
   parameter int IMG_DIM_WIDTH  = 9,
   parameter int ADDR_WIDTH     = 17,
   parameter int REG_ADDR_WIDTH = 3,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      reg_wr_en,
   input  logic                      reg_rd_en,
   input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
   input  logic [DATA_WIDTH-1:0]     reg_wdata,
   output logic [DATA_WIDTH-1:0]     reg_rdata,
   output logic                      reg_rvalid,
   output logic [IMG_DIM_WIDTH-1:0]  img_dim,
   output logic [ADDR_WIDTH-1:0]     in_img_start_addr,
   output logic [ADDR_WIDTH-1:0]     out_img_start_addr,
   output logic                      cfg_check_en,
   input  logic                      cfg_ok,
   input  logic                      cfg_check_done,
   output logic                      core_start,
   input  logic                      core_done,
   output logic                      irq
);

   state_e                     r_state;
   state_e                     w_state_nxt;
   logic                       r_irq_en;
   logic                       r_done;
   logic                       r_cfg_err;
   logic [IMG_DIM_WIDTH-1:0]   r_img_dim;
   logic [ADDR_WIDTH-1:0]      r_in_addr;
   logic [ADDR_WIDTH-1:0]      r_out_addr;
   logic [DATA_WIDTH-1:0]      r_rdata;
   logic                       r_rvalid;

   logic                       w_busy;
   logic                       w_wr_ctrl;
   logic                       w_wr_status;
   logic                       w_wr_img_dim;
   logic                       w_wr_in_addr;
   logic                       w_wr_out_addr;
   logic                       w_start_req;
   logic                       w_job_accept;
   logic                       w_check_en;
   logic                       w_core_start;
   logic                       w_set_done;
   logic                       w_set_err;
   logic                       w_clr_done;
   logic                       w_clr_err;
   logic [DATA_WIDTH-1:0]      w_rd_mux;
   logic                       w_unused_wdata;

   // ------------------------------------------------------------------
   // Register write decode
   // ------------------------------------------------------------------
   assign w_busy        = (r_state != ST_IDLE);
   assign w_wr_ctrl     = reg_wr_en && (reg_addr == REG_ADDR_WIDTH'(c_reg_ctrl));
   assign w_wr_status   = reg_wr_en && (reg_addr == REG_ADDR_WIDTH'(c_reg_status));
   assign w_wr_img_dim  = reg_wr_en && (reg_addr == REG_ADDR_WIDTH'(c_reg_img_dim));
   assign w_wr_in_addr  = reg_wr_en && (reg_addr == REG_ADDR_WIDTH'(c_reg_in_addr));
   assign w_wr_out_addr = reg_wr_en && (reg_addr == REG_ADDR_WIDTH'(c_reg_out_addr));
   assign w_start_req   = w_wr_ctrl && reg_wdata[c_ctrl_start_bit];

   // A job start and a host W1C both clear the sticky flags; a hardware set
   // on the same edge takes priority over either.
   assign w_clr_done = w_job_accept || (w_wr_status && reg_wdata[c_stat_done_bit]);
   assign w_clr_err  = w_job_accept || (w_wr_status && reg_wdata[c_stat_cfg_err_bit]);

   // Only a few write-data bits are architecturally used.
   assign w_unused_wdata = ^reg_wdata;

   // ------------------------------------------------------------------
   // Job sequencer: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Job sequencer: next state and pulse outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_job_accept = 1'b0;
      w_check_en   = 1'b0;
      w_core_start = 1'b0;
      w_set_done   = 1'b0;
      w_set_err    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_req) begin
               w_job_accept = 1'b1;
               w_state_nxt  = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_check_en  = 1'b1;
            w_state_nxt = ST_WAIT_CHECK;
         end
         ST_WAIT_CHECK: begin
            if (cfg_check_done) begin
               if (cfg_ok) begin
                  w_state_nxt = ST_LAUNCH;
               end else begin
                  w_set_done  = 1'b1;
                  w_set_err   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_LAUNCH: begin
            w_core_start = 1'b1;
            w_state_nxt  = ST_WAIT_CORE;
         end
         ST_WAIT_CORE: begin
            if (core_done) begin
               w_set_done  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Read mux (samples pre-write values)
   // ------------------------------------------------------------------
   always_comb begin
      w_rd_mux = '0;
      case (reg_addr)
         REG_ADDR_WIDTH'(c_reg_ctrl): begin
            w_rd_mux[c_ctrl_irq_en_bit] = r_irq_en;
         end
         REG_ADDR_WIDTH'(c_reg_status): begin
            w_rd_mux[c_stat_busy_bit]    = w_busy;
            w_rd_mux[c_stat_done_bit]    = r_done;
            w_rd_mux[c_stat_cfg_err_bit] = r_cfg_err;
         end
         REG_ADDR_WIDTH'(c_reg_img_dim):  w_rd_mux = DATA_WIDTH'(r_img_dim);
         REG_ADDR_WIDTH'(c_reg_in_addr):  w_rd_mux = DATA_WIDTH'(r_in_addr);
         REG_ADDR_WIDTH'(c_reg_out_addr): w_rd_mux = DATA_WIDTH'(r_out_addr);
         REG_ADDR_WIDTH'(c_reg_id):       w_rd_mux = DATA_WIDTH'(c_id_value);
         default:                         w_rd_mux = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_en   <= 1'b0;
         r_done     <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_img_dim  <= '0;
         r_in_addr  <= '0;
         r_out_addr <= '0;
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
      end else begin
         if (w_wr_ctrl) begin
            r_irq_en <= reg_wdata[c_ctrl_irq_en_bit];
         end

         // Job configuration is frozen while a job is in flight.
         if (!w_busy) begin
            if (w_wr_img_dim) begin
               r_img_dim <= reg_wdata[IMG_DIM_WIDTH-1:0];
            end
            if (w_wr_in_addr) begin
               r_in_addr <= reg_wdata[ADDR_WIDTH-1:0];
            end
            if (w_wr_out_addr) begin
               r_out_addr <= reg_wdata[ADDR_WIDTH-1:0];
            end
         end

         if (w_set_done) begin
            r_done <= 1'b1;
         end else if (w_clr_done) begin
            r_done <= 1'b0;
         end

         if (w_set_err) begin
            r_cfg_err <= 1'b1;
         end else if (w_clr_err) begin
            r_cfg_err <= 1'b0;
         end

         r_rvalid <= reg_rd_en;
         if (reg_rd_en) begin
            r_rdata <= w_rd_mux;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign reg_rdata          = r_rdata;
   assign reg_rvalid         = r_rvalid;
   assign img_dim            = r_img_dim;
   assign in_img_start_addr  = r_in_addr;
   assign out_img_start_addr = r_out_addr;
   assign cfg_check_en       = w_check_en;
   assign core_start         = w_core_start;
   assign irq                = r_irq_en & r_done;

endmodule : deskew_ctrl
`default_nettype wire

// File: tb/tb_deskew_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_deskew_ctrl
// Description : Self-checking bench for deskew_ctrl: a register vector table,
//               hand-written job sequences for the corner cases, and random
//               jobs checked against a transaction-level register/job model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deskew_ctrl;

   localparam logic [31:0] c_id = 32'hDE5C_0001;

   logic        clk;
   logic        rst_n;
   logic        reg_wr_en;
   logic        reg_rd_en;
   logic [2:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        reg_rvalid;
   logic [8:0]  img_dim;
   logic [16:0] in_img_start_addr;
   logic [16:0] out_img_start_addr;
   logic        cfg_check_en;
   logic        cfg_ok;
   logic        cfg_check_done;
   logic        core_start;
   logic        core_done;
   logic        irq;

   deskew_ctrl #(
      .IMG_DIM_WIDTH  (9),
      .ADDR_WIDTH     (17),
      .REG_ADDR_WIDTH (3),
      .DATA_WIDTH     (32)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .reg_wr_en          (reg_wr_en),
      .reg_rd_en          (reg_rd_en),
      .reg_addr           (reg_addr),
      .reg_wdata          (reg_wdata),
      .reg_rdata          (reg_rdata),
      .reg_rvalid         (reg_rvalid),
      .img_dim            (img_dim),
      .in_img_start_addr  (in_img_start_addr),
      .out_img_start_addr (out_img_start_addr),
      .cfg_check_en       (cfg_check_en),
      .cfg_ok             (cfg_ok),
      .cfg_check_done     (cfg_check_done),
      .core_start         (core_start),
      .core_done          (core_done),
      .irq                (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters: each high cycle of a pulse output adds one.
   int n_en;
   int n_start;
   initial begin
      n_en    = 0;
      n_start = 0;
   end
   always @(posedge clk) begin
      if (cfg_check_en === 1'b1) n_en <= n_en + 1;
      if (core_start === 1'b1)   n_start <= n_start + 1;
   end

   int checks;
   int failures;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      reg_wr_en = 1'b1;
      reg_addr  = a;
      reg_wdata = d;
      @(posedge clk);
      #1;
      reg_wr_en = 1'b0;
      reg_wdata = '0;
   endtask

   task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      reg_rd_en = 1'b1;
      reg_addr  = a;
      @(posedge clk);
      #1;
      reg_rd_en = 1'b0;
      check("rvalid", {31'b0, reg_rvalid}, 32'd1);
      d = reg_rdata;
   endtask

   task automatic pulse_check_done(input logic ok);
      @(negedge clk);
      cfg_check_done = 1'b1;
      cfg_ok         = ok;
      @(posedge clk);
      #1;
      cfg_check_done = 1'b0;
      cfg_ok         = 1'b0;
   endtask

   task automatic pulse_core_done();
      @(negedge clk);
      core_done = 1'b1;
      @(posedge clk);
      #1;
      core_done = 1'b0;
   endtask

   // Vector table record
   typedef struct {
      logic        wr;
      logic        rd;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Transaction-level model state
   logic        m_irq_en;
   logic        m_done;
   logic        m_err;
   logic [8:0]  m_dim;
   logic [16:0] m_in;
   logic [16:0] m_out;

   function automatic logic [31:0] m_status();
      return {29'b0, m_err, m_done, 1'b0};
   endfunction

   logic [31:0] rd;
   logic [31:0] v;
   int          e0;
   int          s0;
   int          lat;
   logic        ok;

   initial begin
      checks         = 0;
      failures       = 0;
      rst_n          = 1'b0;
      reg_wr_en      = 1'b0;
      reg_rd_en      = 1'b0;
      reg_addr       = '0;
      reg_wdata      = '0;
      cfg_ok         = 1'b0;
      cfg_check_done = 1'b0;
      core_done      = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdata",  reg_rdata, 32'h0);
      check("rst_rvalid", {31'b0, reg_rvalid}, 32'h0);
      check("rst_img_dim", {23'b0, img_dim}, 32'h0);
      check("rst_addrs", {15'b0, in_img_start_addr} | {15'b0, out_img_start_addr}, 32'h0);
      check("rst_pulses", {30'b0, cfg_check_en, core_start}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- register vector table ----------------
      vecs.push_back('{1'b0, 1'b1, 3'd5, 32'h0,          c_id});
      vecs.push_back('{1'b0, 1'b1, 3'd1, 32'h0,          32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'd6, 32'h0,          32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF,  32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'd7, 32'h0,          32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'd5, 32'h0,          32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'd5, 32'h0,          c_id});
      vecs.push_back('{1'b1, 1'b0, 3'd2, 32'hFFFF_FFFF,  32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'd2, 32'h0,          32'h0000_01FF});
      vecs.push_back('{1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF,  32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'd3, 32'h0,          32'h0001_FFFF});
      vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0000_0200,  32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'd4, 32'h0,          32'h0000_0200});
      vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h0000_0010,  32'h0});
      vecs.push_back('{1'b1, 1'b1, 3'd2, 32'h0000_0005,  32'h0000_0010});
      vecs.push_back('{1'b0, 1'b1, 3'd2, 32'h0,          32'h0000_0005});
      vecs.push_back('{1'b1, 1'b0, 3'd0, 32'hFFFF_FFFE,  32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'd0, 32'h0,          32'h0000_0002});
      vecs.push_back('{1'b0, 1'b1, 3'd1, 32'h0,          32'h0});

      foreach (vecs[i]) begin
         @(negedge clk);
         reg_wr_en = vecs[i].wr;
         reg_rd_en = vecs[i].rd;
         reg_addr  = vecs[i].addr;
         reg_wdata = vecs[i].wdata;
         @(posedge clk);
         #1;
         reg_wr_en = 1'b0;
         reg_rd_en = 1'b0;
         check($sformatf("vec%0d_rvalid", i), {31'b0, reg_rvalid}, {31'b0, vecs[i].rd});
         if (vecs[i].rd) check($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].exp);
      end

      // ---------------- good configuration ----------------
      reg_write(3'd2, 32'd16);
      reg_write(3'd3, 32'h0);
      reg_write(3'd4, 32'h200);
      reg_write(3'd0, 32'h2);
      e0 = n_en;
      s0 = n_start;
      reg_write(3'd0, 32'h3);
      check("good_check_en", {31'b0, cfg_check_en}, 32'd1);
      tick();
      check("good_check_en_1cyc", {31'b0, cfg_check_en}, 32'd0);
      repeat (9) tick();
      pulse_check_done(1'b1);
      check("good_core_start", {31'b0, core_start}, 32'd1);
      check("good_img_dim", {23'b0, img_dim}, 32'd16);
      check("good_out_addr", {15'b0, out_img_start_addr}, 32'h200);
      tick();
      check("good_core_start_1cyc", {31'b0, core_start}, 32'd0);
      repeat (3) tick();
      check("good_irq_before_done", {31'b0, irq}, 32'd0);
      pulse_core_done();
      check("good_irq", {31'b0, irq}, 32'd1);
      reg_read(3'd1, rd);
      check("good_status", rd, 32'h2);
      check("good_en_count", n_en - e0, 32'd1);
      check("good_start_count", n_start - s0, 32'd1);

      // ---------------- bad configuration ----------------
      reg_write(3'd1, 32'h2);
      check("w1c_irq_low", {31'b0, irq}, 32'd0);
      reg_write(3'd3, 32'h100);
      reg_write(3'd4, 32'h100);
      e0 = n_en;
      s0 = n_start;
      reg_write(3'd0, 32'h3);
      repeat (4) tick();
      pulse_check_done(1'b0);
      check("bad_no_core_start", {31'b0, core_start}, 32'd0);
      check("bad_irq", {31'b0, irq}, 32'd1);
      repeat (3) tick();
      check("bad_start_count", n_start - s0, 32'd0);
      check("bad_en_count", n_en - e0, 32'd1);
      reg_read(3'd1, rd);
      check("bad_status", rd, 32'h6);
      reg_write(3'd1, 32'h6);
      check("bad_irq_cleared", {31'b0, irq}, 32'd0);
      reg_read(3'd1, rd);
      check("bad_status_cleared", rd, 32'h0);

      // ---------------- busy lockout ----------------
      e0 = n_en;
      s0 = n_start;
      reg_write(3'd0, 32'h3);
      tick();
      reg_write(3'd2, 32'd32);
      reg_write(3'd0, 32'h3);
      reg_read(3'd2, rd);
      check("busy_img_dim_reg", rd, 32'd16);
      check("busy_img_dim_out", {23'b0, img_dim}, 32'd16);
      reg_read(3'd1, rd);
      check("busy_status", rd, 32'h1);
      pulse_check_done(1'b1);
      tick();
      pulse_core_done();
      repeat (4) tick();
      check("busy_en_count", n_en - e0, 32'd1);
      check("busy_start_count", n_start - s0, 32'd1);
      reg_read(3'd1, rd);
      check("busy_status_end", rd, 32'h2);

      // ---------------- W1C / set collision ----------------
      reg_write(3'd0, 32'h3);
      tick();
      pulse_check_done(1'b1);
      tick();
      @(negedge clk);
      core_done = 1'b1;
      reg_wr_en = 1'b1;
      reg_addr  = 3'd1;
      reg_wdata = 32'h2;
      @(posedge clk);
      #1;
      core_done = 1'b0;
      reg_wr_en = 1'b0;
      reg_wdata = '0;
      reg_read(3'd1, rd);
      check("collision_done_wins", rd, 32'h2);

      // ---------------- spurious pulses while idle ----------------
      reg_write(3'd1, 32'h6);
      s0 = n_start;
      pulse_core_done();
      pulse_check_done(1'b1);
      pulse_check_done(1'b0);
      repeat (2) tick();
      reg_read(3'd1, rd);
      check("spurious_status", rd, 32'h0);
      check("spurious_irq", {31'b0, irq}, 32'd0);
      check("spurious_no_start", n_start - s0, 32'd0);

      // ---------------- randomized jobs vs model ----------------
      m_irq_en = 1'b1;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_dim    = 9'd16;
      m_in     = 17'h100;
      m_out    = 17'h100;
      for (int j = 0; j < 24; j++) begin
         if ($urandom_range(0, 1) == 1) begin
            v = $urandom;
            reg_write(3'd2, v);
            m_dim = v[8:0];
         end
         if ($urandom_range(0, 1) == 1) begin
            v = $urandom;
            reg_write(3'd3, v);
            m_in = v[16:0];
         end
         if ($urandom_range(0, 1) == 1) begin
            v = $urandom;
            reg_write(3'd4, v);
            m_out = v[16:0];
         end
         m_irq_en = 1'($urandom_range(0, 1));
         e0 = n_en;
         s0 = n_start;
         reg_write(3'd0, {30'b0, m_irq_en, 1'b1});
         m_done = 1'b0;
         m_err  = 1'b0;
         check("rnd_check_en", {31'b0, cfg_check_en}, 32'd1);
         tick();
         lat = $urandom_range(0, 5);
         for (int k = 0; k < lat; k++) begin
            case ($urandom_range(0, 2))
               0: tick();
               1: reg_write(3'd2, $urandom);
               default: pulse_core_done();
            endcase
         end
         ok = 1'($urandom_range(0, 1));
         pulse_check_done(ok);
         check("rnd_core_start", {31'b0, core_start}, {31'b0, ok});
         if (ok) begin
            tick();
            lat = $urandom_range(0, 5);
            for (int k = 0; k < lat; k++) begin
               case ($urandom_range(0, 2))
                  0: tick();
                  1: reg_write(3'd3, $urandom);
                  default: pulse_check_done(1'($urandom_range(0, 1)));
               endcase
            end
            pulse_core_done();
         end
         m_done = 1'b1;
         m_err  = ~ok;
         check("rnd_irq", {31'b0, irq}, {31'b0, m_irq_en});
         check("rnd_img_dim", {23'b0, img_dim}, {23'b0, m_dim});
         check("rnd_in_addr", {15'b0, in_img_start_addr}, {15'b0, m_in});
         check("rnd_out_addr", {15'b0, out_img_start_addr}, {15'b0, m_out});
         check("rnd_en_count", n_en - e0, 32'd1);
         check("rnd_start_count", n_start - s0, {31'b0, ok});
         reg_read(3'd1, rd);
         check("rnd_status", rd, m_status());
         v = $urandom_range(0, 7);
         reg_write(3'd1, v);
         if (v[1]) m_done = 1'b0;
         if (v[2]) m_err  = 1'b0;
         check("rnd_irq_w1c", {31'b0, irq}, {31'b0, m_irq_en & m_done});
         reg_read(3'd1, rd);
         check("rnd_status_w1c", rd, m_status());
      end

      // ---------------- reset mid WAIT_CORE ----------------
      reg_write(3'd2, 32'd16);
      reg_write(3'd0, 32'h3);
      tick();
      pulse_check_done(1'b1);
      tick();
      reg_read(3'd5, rd);
      check("pre_reset_id", rd, c_id);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_img_dim", {23'b0, img_dim}, 32'h0);
      check("arst_rdata", reg_rdata, 32'h0);
      check("arst_pulses_irq", {29'b0, cfg_check_en, core_start, irq}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      e0 = n_en;
      s0 = n_start;
      repeat (4) tick();
      check("arst_no_pulses", (n_en - e0) + (n_start - s0), 32'd0);
      reg_read(3'd1, rd);
      check("arst_status", rd, 32'h0);
      reg_read(3'd5, rd);
      check("arst_id", rd, c_id);
      reg_read(3'd2, rd);
      check("arst_img_dim_reg", rd, 32'h0);
      reg_read(3'd0, rd);
      check("arst_ctrl", rd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_deskew_ctrl
`default_nettype wire
